led_colour_fader: RTL and testbench

//   Generates the 8-bit duty triple for one RGB LED and feeds the pwm stage (duty_r/g/b -> pwm.duty).

---
 rtl/led_colour_fader_if.sv | 30 +++
 rtl/led_colour_fader.sv | 152 +++++++++++++++
 tb/tb_led_colour_fader.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/led_colour_fader_if.sv
// Control and duty outputs of the RGB colour fader, bundled for the pwm stage.
interface led_colour_fader_if;
  logic       en;
  logic       skip;
  logic [7:0] duty_r;
  logic [7:0] duty_g;
  logic [7:0] duty_b;
  logic [2:0] colour_idx;
  logic       wrap;

  modport master (
    output en,
    output skip,
    input  duty_r,
    input  duty_g,
    input  duty_b,
    input  colour_idx,
    input  wrap
  );

  modport slave (
    input  en,
    input  skip,
    output duty_r,
    output duty_g,
    output duty_b,
    output colour_idx,
    output wrap
  );
endinterface

// File: rtl/led_colour_fader.sv
// Six-colour wheel fader: per colour fade-up, hold, fade-down, hold, then advance.
// Drives one 8-bit duty per channel; all outputs are registered.
module led_colour_fader #(
  parameter int unsigned DIV_BY     = 10_000_000,
  parameter int unsigned MAX_LEVEL  = 64,
  parameter int unsigned STEP       = 1,
  parameter int unsigned HOLD_STEPS = 32
) (
  input logic               clk,
  input logic               rst_n,
  led_colour_fader_if.slave bus
);

  localparam int unsigned CntW  = $clog2(DIV_BY);
  localparam int unsigned HoldW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [CntW-1:0]  CntMax   = CntW'(DIV_BY - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_STEPS - 1);
  localparam logic [8:0]       Step9    = 9'(STEP);
  localparam logic [8:0]       Max9     = 9'(MAX_LEVEL);

  typedef enum logic [1:0] {StFadeUp, StHoldHi, StFadeDown, StHoldLo} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [7:0]       level_q, level_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [2:0]       idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic [7:0]       duty_r_q, duty_g_q, duty_b_q;
  logic             advance;
  logic [8:0]       up_sum;
  logic             en_r, en_g, en_b;

  // Prescaler: skip restarts the tick period from zero.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (bus.skip) begin
      cnt_d = '0;
    end else if (bus.en) begin
      cnt_d  = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
      tick_d = (cnt_q == CntMax);
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    hold_d  = hold_q;
    advance = 1'b0;
    up_sum  = {1'b0, level_q} + Step9;
    if (bus.skip) begin
      state_d = StFadeUp;
      level_d = '0;
      hold_d  = '0;
      advance = 1'b1;
    end else if (tick_q && bus.en) begin
      unique case (state_q)
        StFadeUp: begin
          if (up_sum >= Max9) begin
            level_d = Max9[7:0];
            hold_d  = '0;
            state_d = StHoldHi;
          end else begin
            level_d = up_sum[7:0];
          end
        end
        StHoldHi: begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HoldLast) state_d = StFadeDown;
        end
        StFadeDown: begin
          // Clamp at zero rather than wrapping below it
          if ({1'b0, level_q} <= Step9) begin
            level_d = '0;
            hold_d  = '0;
            state_d = StHoldLo;
          end else begin
            level_d = level_q - Step9[7:0];
          end
        end
        StHoldLo: begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HoldLast) begin
            advance = 1'b1;
            state_d = StFadeUp;
          end
        end
      endcase
    end
  end

  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (advance) begin
      idx_d  = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      wrap_d = (idx_q == 3'd5);
    end
  end

  // Wheel: R, Y, G, C, B, M
  always_comb begin
    en_r = 1'b0;
    en_g = 1'b0;
    en_b = 1'b0;
    case (idx_q)
      3'd0:    en_r = 1'b1;
      3'd1:    begin en_r = 1'b1; en_g = 1'b1; end
      3'd2:    en_g = 1'b1;
      3'd3:    begin en_g = 1'b1; en_b = 1'b1; end
      3'd4:    en_b = 1'b1;
      3'd5:    begin en_r = 1'b1; en_b = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFadeUp;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      level_q  <= '0;
      hold_q   <= '0;
      idx_q    <= '0;
      wrap_q   <= 1'b0;
      duty_r_q <= '0;
      duty_g_q <= '0;
      duty_b_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
      idx_q    <= idx_d;
      wrap_q   <= wrap_d;
      duty_r_q <= en_r ? level_q : 8'd0;
      duty_g_q <= en_g ? level_q : 8'd0;
      duty_b_q <= en_b ? level_q : 8'd0;
    end
  end

  assign bus.duty_r     = duty_r_q;
  assign bus.duty_g     = duty_g_q;
  assign bus.duty_b     = duty_b_q;
  assign bus.colour_idx = idx_q;
  assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_led_colour_fader.sv
// Directed bench for led_colour_fader with DIV_BY=4, MAX_LEVEL=8, STEP=3, HOLD_STEPS=2.
module tb_led_colour_fader;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   wrap_cnt;
  int   wrap_bad;

  // Level seen at each of the 10 ticks of one colour
  int   lv [10] = '{3, 6, 8, 8, 8, 5, 2, 0, 0, 0};
  bit   wr [6]  = '{1, 1, 0, 0, 0, 1};
  bit   wg [6]  = '{0, 1, 1, 1, 0, 0};
  bit   wb [6]  = '{0, 0, 0, 1, 1, 1};

  led_colour_fader_if bus ();

  led_colour_fader #(
    .DIV_BY     (4),
    .MAX_LEVEL  (8),
    .STEP       (3),
    .HOLD_STEPS (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.wrap === 1'b1) begin
        wrap_cnt++;
        if (bus.colour_idx !== 3'd0) wrap_bad++;
      end
    end
  endtask

  task automatic sample_check(input int c, input int j);
    int ci;
    int ei;
    ci = c % 6;
    ei = (j == 9) ? (c + 1) % 6 : ci;
    check($sformatf("idx c%0d j%0d", c, j), 32'(bus.colour_idx), 32'(ei));
    check($sformatf("duty_r c%0d j%0d", c, j), 32'(bus.duty_r), wr[ci] ? 32'(lv[j]) : 0);
    check($sformatf("duty_g c%0d j%0d", c, j), 32'(bus.duty_g), wg[ci] ? 32'(lv[j]) : 0);
    check($sformatf("duty_b c%0d j%0d", c, j), 32'(bus.duty_b), wb[ci] ? 32'(lv[j]) : 0);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    wrap_cnt = 0;
    wrap_bad = 0;
    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.skip = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst duty_r", 32'(bus.duty_r), 0);
    check("rst duty_g", 32'(bus.duty_g), 0);
    check("rst duty_b", 32'(bus.duty_b), 0);
    check("rst idx", 32'(bus.colour_idx), 0);
    check("rst wrap", 32'(bus.wrap), 0);

    // First tick after 4 clks: level 3 on edge 5, duty 3 on edge 6
    rst_n = 1'b1;
    run_cycles(5);
    check("pre_tick duty_r", 32'(bus.duty_r), 0);
    run_cycles(1);

    // Full wheel, one sample per tick
    for (int c = 0; c < 6; c++) begin
      for (int j = 0; j < 10; j++) begin
        if (!(c == 0 && j == 0)) run_cycles(4);
        sample_check(c, j);
      end
      if (c == 4) check("wrap before 5->0", 32'(wrap_cnt), 0);
    end
    check("wrap count wheel", 32'(wrap_cnt), 1);
    check("wrap idx", 32'(wrap_bad), 0);

    // Pause mid fade-down of idx 0
    for (int j = 0; j < 6; j++) begin
      run_cycles(4);
      sample_check(6, j);
    end
    bus.en = 1'b0;
    run_cycles(100);
    check("pause duty_r", 32'(bus.duty_r), 5);
    check("pause duty_g", 32'(bus.duty_g), 0);
    check("pause idx", 32'(bus.colour_idx), 0);
    check("pause wrap", 32'(wrap_cnt), 1);
    bus.en = 1'b1;
    run_cycles(3);
    check("resume early", 32'(bus.duty_r), 5);
    run_cycles(1);
    sample_check(6, 6);
    for (int j = 7; j < 10; j++) begin
      run_cycles(4);
      sample_check(6, j);
    end
    for (int j = 0; j < 10; j++) begin
      run_cycles(4);
      sample_check(1, j);
    end
    for (int j = 0; j < 3; j++) begin
      run_cycles(4);
      sample_check(2, j);
    end

    // skip coincident with the tick in HOLD_HI at idx 2
    run_cycles(2);
    bus.skip = 1'b1;
    run_cycles(1);
    bus.skip = 1'b0;
    check("skip idx", 32'(bus.colour_idx), 3);
    run_cycles(1);
    check("skip duty_g", 32'(bus.duty_g), 0);
    check("skip duty_b", 32'(bus.duty_b), 0);
    run_cycles(4);
    check("skip restart early", 32'(bus.duty_g), 0);
    run_cycles(1);
    check("skip restart g", 32'(bus.duty_g), 3);
    check("skip restart b", 32'(bus.duty_b), 3);
    check("skip restart r", 32'(bus.duty_r), 0);

    // skip ignores en; then wrap via skip at idx 5
    bus.en   = 1'b0;
    bus.skip = 1'b1;
    run_cycles(1);
    bus.skip = 1'b0;
    check("skip en0 idx", 32'(bus.colour_idx), 4);
    bus.en   = 1'b1;
    bus.skip = 1'b1;
    run_cycles(1);
    bus.skip = 1'b0;
    check("skip idx5", 32'(bus.colour_idx), 5);
    wrap_cnt = 0;
    bus.skip = 1'b1;
    run_cycles(1);
    bus.skip = 1'b0;
    run_cycles(1);
    check("skip wrap idx", 32'(bus.colour_idx), 0);
    check("skip wrap pulse", 32'(wrap_cnt), 1);

    // Async reset mid-fade, observed before the next clock edge
    run_cycles(9);
    check("mid fade duty_r", 32'(bus.duty_r), 6);
    #2 rst_n = 1'b0;
    #1;
    check("async duty_r", 32'(bus.duty_r), 0);
    check("async duty_g", 32'(bus.duty_g), 0);
    check("async idx", 32'(bus.colour_idx), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
